// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared encodings and constants for counter_ctrl
// State encodings, timer width and step reset value used by the controller and its timer.
package counter_ctrl_pkg;

  localparam int TIMER_W = 8;
  localparam int STEP_W  = 4;
  localparam logic [STEP_W-1:0] STEP_RESET = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIRE = 3'd1,
    ST_HOLD = 3'd2,
    ST_RPT  = 3'd3,
    ST_SHOW = 3'd4
  } state_e;

  // Both keys pressed together counts as no key at all.
  function automatic logic key_valid(input logic up, input logic down);
    return up ^ down;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - key/step inputs and counter-drive outputs of counter_ctrl
// The slave modport is the controller; master is whatever drives the keys and consumes the pulses.
interface counter_ctrl_if;
  import counter_ctrl_pkg::*;

  logic              key_up;
  logic              key_down;
  logic              show;
  logic              load;
  logic [STEP_W-1:0] step_in;
  logic              enable;
  logic              dir;
  logic [STEP_W-1:0] countValue;
  logic              disp;

  modport master (
    output key_up, key_down, show, load, step_in,
    input  enable, dir, countValue, disp
  );

  modport slave (
    input  key_up, key_down, show, load, step_in,
    output enable, dir, countValue, disp
  );

endinterface

// File: rtl/ctrl_timer.sv
// rtl/ctrl_timer.sv - 8-bit interval timer for the auto-repeat pacing
// done_o fires in the cycle where the count reaches term_i-1, so the next edge lands term_i cycles after clear.
module ctrl_timer
  import counter_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               clear_i,
  input  logic               cnt_en_i,
  input  logic [TIMER_W-1:0] term_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (cnt_en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign done_o = cnt_en_i && (count_q == term_i - 1'b1);

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - key-driven step/auto-repeat controller for an up/down counter
// Emits one-cycle enable pulses with direction and step size; SHOW forces the counter preset.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int HOLD_DELAY    = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic           clock,
  input  logic           clear,
  counter_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic              rpt_q, rpt_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic               key_ok;
  logic               same_key;
  logic               tmr_done;
  logic               tmr_clear;
  logic               tmr_en;
  logic [TIMER_W-1:0] tmr_term;

  assign key_ok   = key_valid(bus.key_up, bus.key_down);
  // A direction flip while holding counts as losing the key.
  assign same_key = key_ok && (bus.key_up == dir_q);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rpt_d   = rpt_q;
    case (state_q)
      ST_IDLE: begin
        rpt_d = 1'b0;
        if (bus.show) begin
          state_d = ST_SHOW;
        end else if (key_ok) begin
          dir_d   = bus.key_up;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        rpt_d   = 1'b1;
        state_d = rpt_q ? ST_RPT : ST_HOLD;
      end
      ST_HOLD, ST_RPT: begin
        if (!same_key) begin
          state_d = ST_IDLE;
        end else if (tmr_done) begin
          state_d = ST_FIRE;
        end
      end
      ST_SHOW: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    if (bus.load && (bus.step_in != '0)) begin
      step_d = bus.step_in;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b1;
      rpt_q   <= 1'b0;
      step_q  <= STEP_RESET;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rpt_q   <= rpt_d;
      step_q  <= step_d;
    end
  end

  // Timer restarts in every FIRE cycle; HOLD waits the long delay, RPT the short one.
  assign tmr_clear = clear || (state_d == ST_FIRE);
  assign tmr_en    = (state_q == ST_FIRE) || (state_q == ST_HOLD) || (state_q == ST_RPT);
  assign tmr_term  = (state_q == ST_RPT) ? TIMER_W'(REPEAT_PERIOD) : TIMER_W'(HOLD_DELAY);

  ctrl_timer u_timer (
    .clock    (clock),
    .clear_i  (tmr_clear),
    .cnt_en_i (tmr_en),
    .term_i   (tmr_term),
    .done_o   (tmr_done)
  );

  assign bus.enable     = (state_q == ST_FIRE) || (state_q == ST_SHOW);
  assign bus.disp       = (state_q != ST_SHOW);
  assign bus.dir        = dir_q;
  assign bus.countValue = step_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed self-checking bench for counter_ctrl
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int NONE = -1;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  counter_ctrl_if bus ();

  counter_ctrl #(.HOLD_DELAY(16), .REPEAT_PERIOD(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Downstream 16-bit counter sharing the clock.
  logic        cnt_clr;
  logic [15:0] cnt;
  always @(posedge clock) begin
    if (cnt_clr) cnt <= 16'h0000;
    else if (bus.enable) begin
      if (!bus.disp)   cnt <= 16'h0580;
      else if (bus.dir) cnt <= cnt + 16'(bus.countValue);
      else             cnt <= cnt - 16'(bus.countValue);
    end
  end

  logic [63:0] en_m, dn_m, dir_m;
  logic [3:0]  cv_log [64];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.key_up = 1'b0; bus.key_down = 1'b0; bus.show = 1'b0;
    bus.load = 1'b0;   bus.step_in = 4'd0;  clear = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic cnt_zero();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load = 1'b1; bus.step_in = v; tick();
    bus.load = 1'b0; bus.step_in = 4'd0;
  endtask

  // Cycle c = the period after the c-th edge of the window; inputs set in cycle c are sampled at edge c+1.
  task automatic run_window(input int n, input int up_lo, input int up_hi, input int dn_lo, input int dn_hi,
                            input int sh_lo, input int sh_hi, input int clr_lo, input int clr_hi,
                            input int ld_at, input int ld_val);
    en_m = '0; dn_m = '0; dir_m = '0;
    for (int c = 0; c < n; c++) begin
      tick();
      en_m[c]   = bus.enable;
      dn_m[c]   = !bus.disp;
      dir_m[c]  = bus.dir;
      cv_log[c] = bus.countValue;
      bus.key_up   = (c >= up_lo && c <= up_hi);
      bus.key_down = (c >= dn_lo && c <= dn_hi);
      bus.show     = (c >= sh_lo && c <= sh_hi);
      clear        = (c >= clr_lo && c <= clr_hi);
      bus.load     = (c == ld_at);
      bus.step_in  = (c == ld_at) ? 4'(ld_val) : 4'd0;
    end
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clear = 1'b1; cnt_clr = 1'b1;
    repeat (2) tick();
    check_eq("rst_enable", bus.enable, 1'b0);
    check_eq("rst_disp", bus.disp, 1'b1);
    check_eq("rst_dir", bus.dir, 1'b1);
    check_eq("rst_step", bus.countValue, 4'd1);
    clear = 1'b0; cnt_clr = 1'b0;
    tick();
    check_eq("rst_counter", cnt, 16'h0000);

    // Single press, with a load landing in the pulse cycle.
    run_window(20, 0, 0, NONE, NONE, NONE, NONE, NONE, NONE, 1, 2);
    check_eq("single_mask", en_m, 64'd1 << 1);
    check_eq("single_dir", dir_m[1], 1'b1);
    check_eq("single_step_in_pulse", cv_log[1], 4'd1);
    check_eq("single_step_after", cv_log[2], 4'd2);
    check_eq("single_counter", cnt, 16'h0001);

    // Auto-repeat downward with step 5; a zero load is ignored.
    do_load(4'd5);
    check_eq("load5", bus.countValue, 4'd5);
    do_load(4'd0);
    check_eq("load0_ignored", bus.countValue, 4'd5);
    cnt_zero();
    run_window(48, NONE, NONE, 0, 39, NONE, NONE, NONE, NONE, NONE, 0);
    check_eq("rpt_mask", en_m, (64'd1 << 1) | (64'd1 << 17) | (64'd1 << 21) | (64'd1 << 25) |
                               (64'd1 << 29) | (64'd1 << 33) | (64'd1 << 37));
    check_eq("rpt_dir", dir_m[20], 1'b0);
    check_eq("rpt_counter", cnt, 16'hFFDD);

    // Conflicting keys.
    cnt_zero();
    run_window(12, 0, 9, 0, 9, NONE, NONE, NONE, NONE, NONE, 0);
    check_eq("both_keys_mask", en_m, 64'd0);
    run_window(34, 0, 29, 20, 29, NONE, NONE, NONE, NONE, NONE, 0);
    check_eq("conflict_mask", en_m, (64'd1 << 1) | (64'd1 << 17));
    check_eq("conflict_dir", dir_m[5], 1'b1);
    check_eq("conflict_counter", cnt, 16'd10);

    // Show beats a key in IDLE; a held show re-enters after returning to IDLE.
    cnt_zero();
    run_window(8, 0, 1, NONE, NONE, 0, 2, NONE, NONE, NONE, 0);
    check_eq("show_en_mask", en_m, (64'd1 << 1) | (64'd1 << 3));
    check_eq("show_disp_mask", dn_m, (64'd1 << 1) | (64'd1 << 3));
    check_eq("show_counter", cnt, 16'h0580);
    check_eq("show_disp_after", bus.disp, 1'b1);

    // Clear during RPT, key held through it.
    run_window(32, NONE, NONE, 0, 25, NONE, NONE, 20, 20, NONE, 0);
    check_eq("midrst_mask", en_m, (64'd1 << 1) | (64'd1 << 17) | (64'd1 << 22));
    check_eq("midrst_step_before", cv_log[20], 4'd5);
    check_eq("midrst_step_after", cv_log[21], 4'd1);
    check_eq("midrst_dir_reset", dir_m[21], 1'b1);
    check_eq("midrst_dir_relatch", dir_m[22], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter HOLD_DELAY, default 16: cycles from the first enable pulse to the first auto-repeat pulse (legal range 2..255).
REQ-002 Parameter REPEAT_PERIOD, default 4: cycles between consecutive auto-repeat pulses (legal range 2..255).
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 clear  in  1  reset, synchronous, active-high.
REQ-005 key_up  in  1  level, debounced; request to count up.
REQ-006 key_down  in  1  level, debounced; request to count down.
REQ-007 show  in  1  level; request to force the display preset.
REQ-008 load  in  1  one-cycle strobe; latch step_in as the new step.
REQ-009 step_in  in  4  new step value.
REQ-010 enable  out  1  one-cycle step pulse to the counter.
REQ-011 dir  out  1  1 = add, 0 = subtract.
REQ-012 countValue  out  4  current step magnitude.
REQ-013 disp  out  1  0 = counter loads its preset (0x0580) on enable; 1 = normal counting.

Function
REQ-014 The FSM SHALL have states IDLE, FIRE, HOLD, RPT and SHOW; all outputs SHALL be Moore, decoded from registered state.
REQ-015 "Key valid" SHALL mean exactly one of key_up/key_down is high; both high SHALL be treated as no key.
REQ-016 In IDLE: if show=1, go to SHOW (show has priority over keys); else if the key is valid, latch dir (key_up -> 1, key_down -> 0) and go to FIRE.
REQ-017 enable SHALL be 1 only in FIRE and SHOW, for exactly one cycle per entry.
REQ-018 Latency: a valid key sampled at edge N SHALL produce enable=1 in cycle N+1.
REQ-019 FIRE SHALL go to HOLD on the first pulse of a press and to RPT on later pulses; FIRE is never extended.
REQ-020 While the same key stays valid, pulses SHALL occur at P, P+HOLD_DELAY, then every REPEAT_PERIOD cycles, where P is the first pulse cycle.
REQ-021 In HOLD or RPT, loss of key validity (release, the other key also pressed, or the direction changing) SHALL return the FSM to IDLE on the next edge with no further pulse.
REQ-022 After release, a new press SHALL re-latch dir and restart from the first-pulse timing.
REQ-023 SHOW SHALL drive disp=0 and enable=1 for one cycle, then go to IDLE; outside SHOW, disp SHALL be 1.
REQ-024 show asserted outside IDLE SHALL be ignored; a show still held on return to IDLE SHALL re-enter SHOW.
REQ-025 load=1 with step_in != 0 SHALL update the step register; the new value SHALL appear on countValue on the next cycle.
REQ-026 load with step_in=0 SHALL be ignored.
REQ-027 A load coinciding with a pulse SHALL NOT alter countValue during that pulse cycle.
REQ-028 dir SHALL change only on IDLE->FIRE and SHALL hold its value otherwise.
REQ-029 The interval timer SHALL be 8 bits, cleared on entry to FIRE, and SHALL never wrap within legal parameter values.

Reset
REQ-030 clear=1 at an edge SHALL set state=IDLE, enable=0, disp=1, dir=1, countValue=1, timer=0 and the repeat flag=0, overriding all other inputs.
REQ-031 clear asserted mid-operation (FIRE, HOLD, RPT, SHOW) SHALL drop enable in the following cycle; no pulse SHALL occur until a key is seen valid after clear deasserts.

Structure
REQ-032 State encodings, the timer width (8) and the step reset value (1) SHALL live in a shared constants package/include, counter_ctrl_pkg.
REQ-033 The interval timer SHALL be a sub-module, ctrl_timer: clear input, count-enable input, 8-bit terminal value, one-cycle done output.
REQ-034 counter_ctrl SHALL connect directly to the counter's enable, dir, countValue and disp inputs, sharing the same clock.

Verification
REQ-035 Reset: clear=1 for 2 cycles -> enable=0, disp=1, dir=1, countValue=1; the counter stays at 0.
REQ-036 Single press: key_up high for cycle 10 only -> enable=1 in cycle 11 only, dir=1; counter 0 -> 1.
REQ-037 Auto-repeat: load step_in=5, then key_down high for cycles 0..39 -> pulses at cycles 1, 17, 21, 25, 29, 33, 37 (7 pulses); counter 0 -> 0xFFDD.
REQ-038 Conflict: key_up and key_down both high -> no pulse; hold key_up 20 cycles, then assert key_down too -> IDLE next edge, no further pulses.
REQ-039 Show: show=1 together with key_up in IDLE -> one cycle with disp=0 and enable=1, counter=0x0580, and no up-pulse in that cycle.
REQ-040 Mid-reset: clear pulsed during RPT with step=5 -> enable=0 next cycle and countValue=1; the held key produces a first pulse only after clear deasserts.
